// File: rtl/nios2_mem_bist.sv
// nios2_mem_bist -- Avalon-MM memory self-test master.
//
// Writes data(i) = seed + i to base_addr + i for i in [0, length), reads the
// range back and compares. Reports pass/fail, mismatch count and the first
// failing word.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   start, abort           launch a test (IDLE only) / stop the running test
//   base_addr, length,     test range and pattern seed, latched on start
//   seed
//   address, byteenable,   Avalon-MM master (fixed 1-cycle read latency,
//   chipselect, write,     no waitrequest)
//   writedata, readdata
//   busy, done             running / one-cycle end-of-test pulse
//   pass, cfg_err, aborted result flags, valid from done to next start
//   err_count,             mismatch count and first mismatch capture
//   first_err_addr,
//   first_err_data
module nios2_mem_bist #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 5120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [31:0]       seed,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  input  logic [31:0]       readdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              cfg_err,
  output logic              aborted,
  output logic [ADDR_W-1:0] err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [31:0]       first_err_data
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_FLUSH, S_DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t state, state_nxt;

  // Configuration latched at start so the inputs may change during a test.
  logic [ADDR_W-1:0] base_q, last_q;
  logic [31:0]       seed_q;

  // idx/pat track the word currently on the bus; the outputs themselves are
  // registered copies computed from the next-state logic.
  logic [ADDR_W-1:0] idx, idx_nxt, addr_nxt;
  logic [31:0]       pat, pat_nxt, wdata_nxt;
  logic              cs_nxt, wr_nxt, busy_nxt, done_nxt;

  // Compare stage: a read on the bus this cycle has its data next cycle.
  logic              cmp_vld;
  logic [31:0]       cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;

  logic [ADDR_W:0] range_end;
  logic            range_bad, len_zero, at_last, mismatch, run_st;

  assign range_end = {1'b0, base_addr} + {1'b0, length};
  assign range_bad = range_end > DEPTH_L;
  assign len_zero  = (length == '0);
  assign at_last   = (idx == last_q);
  assign mismatch  = cmp_vld && (readdata != cmp_exp);
  assign run_st    = (state == S_WRITE) || (state == S_READ) || (state == S_FLUSH);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pat_nxt   = pat;
    addr_nxt  = '0;
    wdata_nxt = '0;
    cs_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len_zero || range_bad) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_WRITE;
            idx_nxt   = '0;
            pat_nxt   = seed;
            addr_nxt  = base_addr;
            wdata_nxt = seed;
            cs_nxt    = 1'b1;
            wr_nxt    = 1'b1;
            busy_nxt  = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (abort) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else if (at_last) begin
          // Back-to-back into the first read, no turnaround.
          state_nxt = S_READ;
          idx_nxt   = '0;
          pat_nxt   = seed_q;
          addr_nxt  = base_q;
          cs_nxt    = 1'b1;
          busy_nxt  = 1'b1;
        end else begin
          idx_nxt   = idx + 1'b1;
          pat_nxt   = pat + 32'd1;
          addr_nxt  = address + 1'b1;
          wdata_nxt = pat + 32'd1;
          cs_nxt    = 1'b1;
          wr_nxt    = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      S_READ: begin
        if (abort) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else if (at_last) begin
          state_nxt = S_FLUSH;
          busy_nxt  = 1'b1;
        end else begin
          idx_nxt   = idx + 1'b1;
          pat_nxt   = pat + 32'd1;
          addr_nxt  = address + 1'b1;
          cs_nxt    = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      S_FLUSH: begin
        state_nxt = S_DONE;
        done_nxt  = 1'b1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      pat            <= '0;
      base_q         <= '0;
      last_q         <= '0;
      seed_q         <= '0;
      address        <= '0;
      byteenable     <= '0;
      chipselect     <= 1'b0;
      write          <= 1'b0;
      writedata      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      cmp_vld        <= 1'b0;
      cmp_exp        <= '0;
      cmp_addr       <= '0;
      pass           <= 1'b0;
      cfg_err        <= 1'b0;
      aborted        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      pat        <= pat_nxt;
      address    <= addr_nxt;
      byteenable <= cs_nxt ? 4'hF : 4'h0;
      chipselect <= cs_nxt;
      write      <= wr_nxt;
      writedata  <= wdata_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;

      // Arm a compare for each read on the bus; abort drops it.
      cmp_vld  <= (state == S_READ) && !abort;
      cmp_exp  <= pat;
      cmp_addr <= address;

      if (state == S_IDLE && start) begin
        base_q         <= base_addr;
        last_q         <= length - 1'b1;
        seed_q         <= seed;
        pass           <= len_zero;
        cfg_err        <= !len_zero && range_bad;
        aborted        <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
        first_err_data <= '0;
      end else if (run_st && abort) begin
        aborted <= 1'b1;
        pass    <= 1'b0;
      end else begin
        if (mismatch) begin
          err_count <= err_count + 1'b1;
          if (err_count == '0) begin
            first_err_addr <= cmp_addr;
            first_err_data <= readdata;
          end
        end
        // The last compare lands in FLUSH, so fold it into the verdict here.
        if (state == S_FLUSH)
          pass <= (err_count == '0) && !mismatch;
      end
    end
  end

endmodule

// File: tb/tb_nios2_mem_bist.sv
// Directed bench for nios2_mem_bist with a 1-cycle-latency behavioural memory.
module tb_nios2_mem_bist;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort;
  logic [12:0] base_addr, length;
  logic [31:0] seed;
  logic [12:0] address;
  logic [3:0]  byteenable;
  logic        chipselect, write;
  logic [31:0] writedata, readdata;
  logic        busy, done, pass, cfg_err, aborted;
  logic [12:0] err_count, first_err_addr;
  logic [31:0] first_err_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nios2_mem_bist #(.ADDR_W(13), .DEPTH(5120)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .seed(seed),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(readdata),
    .busy(busy), .done(done), .pass(pass), .cfg_err(cfg_err),
    .aborted(aborted), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data)
  );

  // Behavioural memory; fault_en flips bit0 of reads from words 5 and 7.
  logic [31:0] mem [0:5119];
  logic        fault_en = 1'b0;

  always @(posedge clk) begin
    if (chipselect && write && address < 13'd5120)
      mem[address] <= writedata;
    if (chipselect && !write && address < 13'd5120)
      readdata <= mem[address] ^
                  {31'd0, fault_en && (address == 13'd5 || address == 13'd7)};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-run observations.
  int          r_lat, r_bus, r_wrs, r_gap, r_be_bad;
  logic        r_first_busy, r_cs_after;
  logic [12:0] r_first_addr;
  logic [31:0] r_first_wd;
  logic [31:0] wd_log [0:15];

  // Launch a test, then watch the bus until done (bounded).
  task automatic run(input logic [12:0] b, input logic [12:0] l, input logic [31:0] s,
                     input bit hold, input int abort_at);
    @(negedge clk);
    base_addr = b; length = l; seed = s; start = 1'b1;
    r_lat = 0; r_bus = 0; r_wrs = 0; r_gap = 0; r_be_bad = 0;
    r_first_busy = 1'b0; r_first_addr = '0; r_first_wd = '0; r_cs_after = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 20000; n++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (n == 1) begin
        r_first_busy = busy; r_first_addr = address; r_first_wd = writedata;
      end
      if (n == abort_at) abort = 1'b1;
      if (n == abort_at + 1) begin
        r_cs_after = chipselect;
        abort = 1'b0;
      end
      if (chipselect) r_bus++;
      if (chipselect && write) begin
        if (r_wrs < 16) wd_log[r_wrs] = writedata;
        r_wrs++;
      end
      if (n <= 2 * int'(l) && !chipselect) r_gap++;
      if ((chipselect && byteenable != 4'hF) || (!chipselect && byteenable != 4'h0))
        r_be_bad++;
      if (done) begin
        r_lat = n;
        start = 1'b0;
        break;
      end
    end
    if (r_lat == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    base_addr = '0; length = '0; seed = '0;
    #1;
    chk("rst_flags", {25'd0, busy, done, pass, chipselect, write, cfg_err, aborted}, 32'd0);
    chk("rst_addr", {19'd0, address}, 32'd0);
    chk("rst_be", {28'd0, byteenable}, 32'd0);
    chk("rst_errcnt", {19'd0, err_count}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Normal pass
    run(13'd0, 13'd4, 32'hA5A5_0000, 1'b0, 0);
    chk("norm_lat", r_lat, 32'd10);
    chk("norm_busy1", {31'd0, r_first_busy}, 32'd1);
    chk("norm_addr0", {19'd0, r_first_addr}, 32'd0);
    chk("norm_wd0", r_first_wd, 32'hA5A5_0000);
    chk("norm_bus", r_bus, 32'd8);
    chk("norm_wrs", r_wrs, 32'd4);
    chk("norm_gap", r_gap, 32'd0);
    chk("norm_be", r_be_bad, 32'd0);
    chk("norm_busy_done", {31'd0, busy}, 32'd0);
    chk("norm_pass", {31'd0, pass}, 32'd1);
    chk("norm_err", {19'd0, err_count}, 32'd0);
    chk("norm_mem3", mem[3], 32'hA5A5_0003);

    // Fault injection on words 5 and 7
    fault_en = 1'b1;
    run(13'd4, 13'd8, 32'h1234_5678, 1'b0, 0);
    fault_en = 1'b0;
    chk("flt_lat", r_lat, 32'd18);
    chk("flt_err", {19'd0, err_count}, 32'd2);
    chk("flt_faddr", {19'd0, first_err_addr}, 32'd5);
    chk("flt_fdata", first_err_data, 32'h1234_5678);  // (seed+1)^1
    chk("flt_pass", {31'd0, pass}, 32'd0);

    // Range boundary
    run(13'd5119, 13'd1, 32'h0000_0042, 1'b0, 0);
    chk("top1_lat", r_lat, 32'd4);
    chk("top1_pass", {31'd0, pass}, 32'd1);
    chk("top1_cfg", {31'd0, cfg_err}, 32'd0);
    chk("top1_err", {19'd0, err_count}, 32'd0);
    run(13'd5119, 13'd2, 32'h0000_0042, 1'b0, 0);
    chk("top2_lat", r_lat, 32'd1);
    chk("top2_cfg", {31'd0, cfg_err}, 32'd1);
    chk("top2_pass", {31'd0, pass}, 32'd0);
    chk("top2_bus", r_bus, 32'd0);
    run(13'd100, 13'd0, 32'h0000_0042, 1'b0, 0);
    chk("zero_lat", r_lat, 32'd1);
    chk("zero_pass", {31'd0, pass}, 32'd1);
    chk("zero_cfg", {31'd0, cfg_err}, 32'd0);
    chk("zero_bus", r_bus, 32'd0);

    // Abort during the 3rd read (reads occupy cycles 7..12)
    run(13'd10, 13'd6, 32'h0BAD_F00D, 1'b0, 9);
    chk("abt_cs", {31'd0, r_cs_after}, 32'd0);
    chk("abt_flag", {31'd0, aborted}, 32'd1);
    chk("abt_pass", {31'd0, pass}, 32'd0);
    run(13'd0, 13'd3, 32'h0000_1000, 1'b0, 0);
    chk("post_abt_lat", r_lat, 32'd8);
    chk("post_abt_pass", {31'd0, pass}, 32'd1);
    chk("post_abt_flag", {31'd0, aborted}, 32'd0);

    // start held high: one test per acceptance
    run(13'd200, 13'd5, 32'h5555_0000, 1'b1, 0);
    chk("hold_lat", r_lat, 32'd12);
    chk("hold_wrs", r_wrs, 32'd5);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("hold_idle", {30'd0, busy, chipselect}, 32'd0);

    // Async reset mid-WRITE
    @(negedge clk);
    base_addr = 13'd20; length = 13'd6; seed = 32'h7777_0000; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("mid_wr", {31'd0, write}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_flags", {25'd0, busy, done, pass, chipselect, write, cfg_err, aborted}, 32'd0);
    chk("mid_rst_bus", {writedata[18:0], address}, 32'd0);
    chk("mid_rst_be", {28'd0, byteenable}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run(13'd20, 13'd6, 32'h7777_0000, 1'b0, 0);
    chk("after_rst_lat", r_lat, 32'd14);
    chk("after_rst_pass", {31'd0, pass}, 32'd1);

    // Seed wrap
    run(13'd100, 13'd3, 32'hFFFF_FFFE, 1'b0, 0);
    chk("wrap_wd0", wd_log[0], 32'hFFFF_FFFE);
    chk("wrap_wd1", wd_log[1], 32'hFFFF_FFFF);
    chk("wrap_wd2", wd_log[2], 32'h0000_0000);
    chk("wrap_pass", {31'd0, pass}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nios2_mem_bist.md
# nios2_mem_bist

Avalon-MM master that exercises the Nios II on-chip memory's s1/s2 slave port from the initiator side. It writes a deterministic pattern over a programmable word range, reads the range back, and reports pass/fail with an error count and the first failing location. It sits beside the CPU on the memory's second slave port and is used in the testbench and in the hardware self-test image.

## Interface
- ADDR_W, 13, word-address width; matches the memory's address bus.
- DEPTH, 5120, number of 32-bit words implemented in the memory.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a test; sampled only in IDLE.
- abort  in  1  stop the current test at the next edge.
- base_addr  in  ADDR_W  first word address of the test range.
- length  in  ADDR_W  number of words to test.
- seed  in  32  pattern seed.
- address  out  ADDR_W  Avalon word address.
- byteenable  out  4  always 4'hF while chipselect=1, else 0.
- chipselect  out  1  Avalon chipselect.
- write  out  1  Avalon write strobe.
- writedata  out  32  Avalon write data.
- readdata  in  32  Avalon read data; valid exactly one cycle after a read is issued.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  result; valid from done until the next accepted start.
- cfg_err  out  1  range rejected.
- aborted  out  1  test ended by abort.
- err_count  out  ADDR_W  number of mismatching words.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- first_err_data  out  32  readdata at the first mismatch.

## Operation
- The FSM has five states: IDLE, WRITE, READ, FLUSH and DONE. All outputs are registered.
- Pattern for word i (0 ≤ i < length): data(i) = seed + i, 32-bit modulo add. Address(i) = base_addr + i.
- **IDLE, start=1:**
  - All result registers clear: pass, cfg_err, aborted, err_count, first_err_*.
  - If length=0, go to DONE with pass=1.
  - If base_addr+length > DEPTH (computed at ADDR_W+1 bits), go to DONE with cfg_err=1 and pass=0.
  - Otherwise go to WRITE with i=0.
- **WRITE:** issue one write per cycle: chipselect=1, write=1, address=Address(i), writedata=data(i). After i=length-1, go to READ with i=0.
- **READ:** issue one read per cycle: chipselect=1, write=0. After i=length-1, go to FLUSH.
- **Compare:** the comparison runs every cycle following a read issue, in READ and in FLUSH.
  - On readdata ≠ data(i_prev), increment err_count.
  - On the first mismatch only, capture first_err_addr and first_err_data.
- **FLUSH:** one cycle with chipselect=0, used to compare the last read. Then go to DONE.
- **DONE:** done=1 for one cycle. pass=1 only if err_count=0, cfg_err=0 and aborted=0. Then go to IDLE.
- **abort=1 in WRITE, READ or FLUSH:** the bus goes idle at the next edge, any pending compare is discarded, then the FSM goes to DONE with aborted=1 and pass=0. abort in IDLE or DONE is ignored.
- start while busy is ignored. If start and abort are both high in IDLE, start is accepted and abort is ignored.
- err_count cannot overflow, because length ≤ DEPTH < 2^ADDR_W.

## Timing
- **Reset (asynchronous):** state=IDLE; every output is 0, including byteenable.
- **Start latency:** with start high at edge k in IDLE, the first write is on the bus in cycle k+1, and busy=1 from k+1.
- **Normal run:** the bus is busy for 2·length cycles with no gaps and no waitrequest. FLUSH is 1 cycle. done is asserted in cycle k+2·length+2, and busy falls in the same cycle.
- **Zero length or rejected range:** done is asserted in cycle k+1.
- **Read latency:** fixed at 1 cycle. The read issued in cycle c is compared against readdata in cycle c+1.
- **WRITE→READ boundary:** back-to-back. The first read immediately follows the last write, with no turnaround cycle.
- **Reset mid-test:** the bus is released immediately and results are lost.

## Test plan
- **Normal pass:** base=0, length=4, seed=32'hA5A5_0000, against the behavioural memory. Writes 0..3 carry A5A50000..A5A50003. done occurs 10 cycles after start; pass=1, err_count=0.
- **Fault injection:** bench forces readdata bit0 flipped for addresses 5 and 7 in a base=4, length=8 run. err_count=2, first_err_addr=5, first_err_data = (seed+1)^1, pass=0.
- **Range boundary:**
  - base=5119, length=1: runs and passes.
  - base=5119, length=2: cfg_err=1, done one cycle after start, no bus activity.
  - length=0: pass=1, no bus activity.
- **Abort:** abort pulsed during the 3rd read of length=6. Bus idle next cycle, done with aborted=1, pass=0; the subsequent start runs cleanly.
- **Start ignored when busy; async reset:**
  - start held high throughout a test: exactly one test executes per acceptance.
  - reset asserted mid-WRITE: all outputs 0 with no clock edge; next start behaves normally.
- **Seed wrap:** seed=32'hFFFF_FFFE, length=3. Data sequence is FFFFFFFE, FFFFFFFF, 00000000; pass=1.
